// File: rtl/dmem_line_responder_pkg.sv
// Shared constants and FSM state type for the off-chip line memory model.
package dmem_pkg;
   localparam int LINE_W          = 256;
   localparam int OFFSET_BITS     = 5;
   localparam int DEFAULT_DEPTH   = 512;
   localparam int DEFAULT_LATENCY = 10;
   localparam int CNT_W           = 8;

   typedef enum logic [1:0] {IDLE, BUSY, ACK} state_e;
endpackage

// File: rtl/dmem_line_responder_if.sv
// Cache-controller <-> line memory request/ack bus. Signal names follow the memory's view.
interface dmem_line_responder_if;
   import dmem_pkg::*;

   logic              enable_i;
   logic              write_i;
   logic [31:0]       addr_i;
   logic [LINE_W-1:0] data_i;
   logic              ack_o;
   logic [LINE_W-1:0] data_o;

   modport master (output enable_i, write_i, addr_i, data_i, input  ack_o, data_o);
   modport slave  (input  enable_i, write_i, addr_i, data_i, output ack_o, data_o);
endinterface

// File: rtl/dmem_line_responder_array.sv
// Line storage: one synchronous write port, combinational read on the same index, no reset.
module dmem_line_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_idx,
   input  logic [LINE_W-1:0] i_wdata,
   output logic [LINE_W-1:0] o_rdata
);
   logic [LINE_W-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_idx] <= i_wdata;
   end

   assign o_rdata = r_mem[i_idx];
endmodule

// File: rtl/dmem_line_responder.sv
// Fixed-latency line memory: accepts one request, acks LATENCY cycles later, reads return data with the ack.
module dmem_line_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH   = DEFAULT_DEPTH,
   parameter int LATENCY = DEFAULT_LATENCY
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   dmem_line_responder_if.slave  bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LATENCY - 1);

   if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
      $error("dmem_line_responder: LATENCY %0d outside 1..255", LATENCY);
   end

   state_e             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [IDX_W-1:0]   r_idx;
   logic               r_write;
   logic [LINE_W-1:0]  r_wdata;
   logic               r_ack;
   logic [LINE_W-1:0]  r_data;

   logic [IDX_W-1:0]   w_idx;
   logic [LINE_W-1:0]  w_rdata;
   logic               w_we;

   // In IDLE the array looks at the incoming index so LATENCY=1 reads can return data at once.
   assign w_idx = (r_state == IDLE) ? bus.addr_i[OFFSET_BITS +: IDX_W] : r_idx;
   assign w_we  = (r_state == ACK) && r_write;

   dmem_line_array #(.DEPTH(DEPTH)) u_array (
      .i_clk   (clk_i),
      .i_we    (w_we),
      .i_idx   (w_idx),
      .i_wdata (r_wdata),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_write <= 1'b0;
         r_wdata <= '0;
         r_ack   <= 1'b0;
         r_data  <= '0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.enable_i) begin
                  r_idx   <= bus.addr_i[OFFSET_BITS +: IDX_W];
                  r_write <= bus.write_i;
                  r_wdata <= bus.data_i;
                  r_cnt   <= CNT_W'(1);
                  if (LATENCY == 1) begin
                     r_state <= ACK;
                     r_ack   <= 1'b1;
                     if (!bus.write_i) r_data <= w_rdata;
                  end else begin
                     r_state <= BUSY;
                  end
               end
            end
            BUSY: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST) begin
                  r_state <= ACK;
                  r_ack   <= 1'b1;
                  if (!r_write) r_data <= w_rdata;
               end
            end
            // A request still held during ACK is the one being acked, not a new one.
            ACK:     r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.ack_o  = r_ack;
   assign bus.data_o = r_data;
endmodule

// File: tb/tb_dmem_line_responder.sv
// Scoreboard bench for dmem_line_responder: latency, ack width, data, wrap, busy-input and reset cases.
module tb_dmem_line_responder;
   import dmem_pkg::*;

   localparam int LAT = 10;
   localparam int DEP = 512;

   typedef struct {
      bit                wr;
      logic [LINE_W-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   exp_t              sb[$];
   logic [LINE_W-1:0] model [int];

   dmem_line_responder_if bus();

   dmem_line_responder #(.DEPTH(DEP), .LATENCY(LAT)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   localparam logic [LINE_W-1:0] PAT_A5 = {32{8'hA5}};
   localparam logic [LINE_W-1:0] PAT_D1 = {8{32'h1234_5678}};
   localparam logic [LINE_W-1:0] PAT_P  = {4{64'hDEAD_BEEF_0BAD_F00D}};
   localparam logic [LINE_W-1:0] PAT_Q  = {16{16'h3C96}};
   localparam logic [LINE_W-1:0] PAT_R1 = {8{32'hCAFE_0001}};
   localparam logic [LINE_W-1:0] PAT_R2 = {8{32'h5555_AAAA}};

   task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int idx_of(input logic [31:0] a);
      return int'((a >> OFFSET_BITS) % DEP);
   endfunction

   // Waits (bounded) for the next ack, then pops the scoreboard and checks read data.
   task automatic wait_ack(input string tag, output int at);
      exp_t e;
      at = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.ack_o) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         chk({tag, "_timeout"}, LINE_W'(bus.ack_o), LINE_W'(1));
         return;
      end
      if (sb.size() == 0) begin
         chk({tag, "_spurious"}, LINE_W'(sb.size()), LINE_W'(1));
         return;
      end
      e = sb.pop_front();
      if (!e.wr) chk({tag, "_data"}, bus.data_o, e.data);
   endtask

   task automatic req(input bit w, input logic [31:0] a, input logic [LINE_W-1:0] d,
                      input bit flip, input string tag);
      int   c0;
      int   at;
      exp_t e;
      @(negedge clk);
      bus.enable_i = 1'b1;
      bus.write_i  = w;
      bus.addr_i   = a;
      bus.data_i   = d;
      c0 = cyc;
      e.wr   = w;
      e.data = w ? d : model[idx_of(a)];
      sb.push_back(e);
      if (w) model[idx_of(a)] = d;
      if (flip) begin
         repeat (3) @(negedge clk);
         bus.addr_i  = a ^ 32'h0000_0140;
         bus.write_i = ~w;
         bus.data_i  = ~d;
      end
      wait_ack(tag, at);
      bus.enable_i = 1'b0;
      if (at >= 0) begin
         chk({tag, "_lat"}, LINE_W'(at - c0), LINE_W'(LAT));
         @(negedge clk);
         chk({tag, "_width"}, LINE_W'(bus.ack_o), LINE_W'(0));
      end
   endtask

   initial begin
      int c0, a1, a2;
      bit seen;
      exp_t e;
      bus.enable_i = 1'b0;
      bus.write_i  = 1'b0;
      bus.addr_i   = '0;
      bus.data_i   = '0;

      // Power-up reset, checked before any clock edge acts on it.
      #2 rst = 1'b1;
      #1;
      chk("rst0_ack", LINE_W'(bus.ack_o), LINE_W'(0));
      chk("rst0_data", bus.data_o, '0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      req(1'b1, 32'h0000_0040, PAT_A5, 1'b0, "wr40");
      req(1'b0, 32'h0000_0040, '0,     1'b0, "rd40");

      req(1'b1, 32'h0000_0041, PAT_D1, 1'b0, "wr41");
      req(1'b0, 32'h0000_4040, '0,     1'b0, "rd4040");

      req(1'b1, 32'h0000_01E0, PAT_Q,  1'b0, "wr1e0");
      req(1'b1, 32'h0000_00A0, PAT_P,  1'b1, "wrflip");
      req(1'b0, 32'h0000_00A0, '0,     1'b0, "rdA0");
      req(1'b0, 32'h0000_01E0, '0,     1'b0, "rd1e0");

      // Back-to-back: enable stays high through the first ack.
      @(negedge clk);
      bus.enable_i = 1'b1;
      bus.write_i  = 1'b0;
      bus.addr_i   = 32'h0000_0040;
      c0 = cyc;
      e.wr = 1'b0;
      e.data = model[idx_of(32'h40)];
      sb.push_back(e);
      sb.push_back(e);
      wait_ack("b2b1", a1);
      wait_ack("b2b2", a2);
      bus.enable_i = 1'b0;
      chk("b2b_lat", LINE_W'(a1 - c0), LINE_W'(LAT));
      chk("b2b_gap", LINE_W'(a2 - a1), LINE_W'(LAT + 1));

      // Reset in the middle of a write: line must keep its prior contents.
      req(1'b1, 32'h0000_00E0, PAT_R1, 1'b0, "wrE0");
      req(1'b0, 32'h0000_0040, '0,     1'b0, "rd40b");
      @(negedge clk);
      bus.enable_i = 1'b1;
      bus.write_i  = 1'b1;
      bus.addr_i   = 32'h0000_00E0;
      bus.data_i   = PAT_R2;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rstmid_ack", LINE_W'(bus.ack_o), LINE_W'(0));
      chk("rstmid_data", bus.data_o, '0);
      bus.enable_i = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus.ack_o) seen = 1'b1;
      end
      chk("rstmid_noack", LINE_W'(seen), LINE_W'(0));
      req(1'b0, 32'h0000_00E0, '0, 1'b0, "rdE0");

      chk("sb_empty", LINE_W'(sb.size()), LINE_W'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
